// File: rtl/vga_sprite_stage.sv
// vga_sprite_stage: overlays a 16x16 one-bit sprite on a VGA beam with a two-stage en-gated pipeline.
// Sprite position updates are double-buffered and only take effect at the vertical apply point.
module vga_sprite_stage #(
    parameter int H_DISPLAY = 640,
    parameter int V_DISPLAY = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [9:0]  hpos,
    input  logic [9:0]  vpos,
    input  logic        display_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        pos_valid,
    output logic        pos_ready,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    input  logic        bmp_we,
    input  logic [3:0]  bmp_row,
    input  logic [15:0] bmp_data,
    input  logic [5:0]  fg_color,
    input  logic [5:0]  bg_color,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic [5:0]  rgb,
    output logic        frame_tick
);
    logic [15:0] r_bmp [16];
    logic [9:0]  r_act_x, r_act_y, r_pend_x, r_pend_y;
    logic        r_pend;
    logic [3:0]  r_dx, r_dy;
    logic        r_in, r_de, r_hs, r_vs;
    logic [5:0]  r_rgb;
    logic        r_hs_out, r_vs_out;

    logic        w_apply, w_accept, w_inside, w_bit;
    logic [9:0]  w_dx, w_dy;
    logic [15:0] w_row;

    assign w_apply  = en && hpos == 10'd0 && vpos == 10'(V_DISPLAY);
    assign w_accept = pos_valid && !r_pend;
    // Wrap is modulo 1024, so a sprite hanging off the left/top edge shows its tail columns/rows.
    assign w_dx     = hpos - r_act_x;
    assign w_dy     = vpos - r_act_y;
    assign w_inside = display_on && hpos < 10'(H_DISPLAY) && w_dx < 10'd16 && w_dy < 10'd16;
    assign w_row    = r_bmp[r_dy];
    assign w_bit    = w_row[~r_dx];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend   <= 1'b0;
            r_act_x  <= '0;
            r_act_y  <= '0;
            r_pend_x <= '0;
            r_pend_y <= '0;
            for (int i = 0; i < 16; i++) r_bmp[i] <= '0;
        end else begin
            if (w_apply) begin
                r_pend <= 1'b0;
                if (w_accept) begin
                    r_act_x <= pos_x;
                    r_act_y <= pos_y;
                end else if (r_pend) begin
                    r_act_x <= r_pend_x;
                    r_act_y <= r_pend_y;
                end
            end else if (w_accept) begin
                r_pend_x <= pos_x;
                r_pend_y <= pos_y;
                r_pend   <= 1'b1;
            end
            if (bmp_we) r_bmp[bmp_row] <= bmp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            {r_dx, r_dy, r_in, r_de, r_hs, r_vs} <= '0;
            {r_rgb, r_hs_out, r_vs_out} <= '0;
        end else if (en) begin
            r_dx     <= w_dx[3:0];
            r_dy     <= w_dy[3:0];
            r_in     <= w_inside;
            r_de     <= display_on;
            r_hs     <= hsync_in;
            r_vs     <= vsync_in;
            r_rgb    <= !r_de ? 6'd0 : (r_in && w_bit) ? fg_color : bg_color;
            r_hs_out <= r_hs;
            r_vs_out <= r_vs;
        end
    end

    assign pos_ready  = !r_pend;
    assign frame_tick = w_apply && !reset;
    assign rgb        = r_rgb;
    assign hsync_out  = r_hs_out;
    assign vsync_out  = r_vs_out;
endmodule
